// File: rtl/vga_capture_if.sv
// Framebuffer write port of the VGA capture block.
// fb_write is a one-cycle strobe with no ready: the receiver must accept a word on every cycle it is high.
interface vga_capture_if;
    logic        fb_write;
    logic [14:0] fb_address;
    logic [31:0] fb_writedata;

    modport master (output fb_write, fb_address, fb_writedata);
    modport slave  (input  fb_write, fb_address, fb_writedata);
endinterface

// File: rtl/vga_capture.sv
// Captures one full 1-bit-per-pixel VGA frame into a 32-bit-word framebuffer,
// packing pixels LSB first and writing each word the cycle after its last sample.
module vga_capture #(
    parameter int HPIX   = 640,
    parameter int VPIX   = 480,
    parameter int NWORDS = HPIX * VPIX / 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          VGA_VS,
    input  logic          VGA_BLANK_n,
    input  logic          pix_en,
    input  logic          pix,
    vga_capture_if.master fb,
    output logic          busy,
    output logic          done,
    output logic          err_short,
    output logic [1:0]    dbg_state
);
    typedef enum logic [1:0] {IDLE, ARM, SYNC, CAPTURE} state_t;

    localparam logic [14:0] LAST_ADDR = 15'(NWORDS - 1);

    state_t      state;
    logic [4:0]  bit_cnt;
    logic [14:0] word_cnt;
    logic [31:0] shift;
    logic        sample;
    logic        word_done;

    assign sample    = pix_en && VGA_BLANK_n;
    assign word_done = sample && (bit_cnt == 5'd31);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            word_cnt        <= '0;
            shift           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_short       <= 1'b0;
            fb.fb_write     <= 1'b0;
            fb.fb_address   <= '0;
            fb.fb_writedata <= '0;
        end else begin
            fb.fb_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        done      <= 1'b0;
                        err_short <= 1'b0;
                        bit_cnt   <= '0;
                        word_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= ARM;
                    end
                end
                ARM: begin
                    if (!VGA_VS) state <= SYNC;
                end
                SYNC: begin
                    if (VGA_VS) state <= CAPTURE;
                end
                CAPTURE: begin
                    if (sample) begin
                        shift[bit_cnt] <= pix;
                        bit_cnt        <= bit_cnt + 5'd1;
                    end
                    // The completing sample bypasses the shift register so the word goes out next cycle.
                    if (word_done) begin
                        fb.fb_write     <= 1'b1;
                        fb.fb_address   <= word_cnt;
                        fb.fb_writedata <= {pix, shift[30:0]};
                        word_cnt        <= word_cnt + 15'd1;
                    end
                    if (word_done && word_cnt == LAST_ADDR) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (!VGA_VS) begin
                        // Frame ended early: any partial word is dropped.
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        err_short <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_capture.sv
// Randomized frame-level bench for vga_capture on a reduced 64x48 frame (96 words).
// Expected writes are rebuilt from the accepted pixel stream by chopping it into 32-bit words.
module tb_vga_capture;
    localparam int HPIX   = 64;
    localparam int VPIX   = 48;
    localparam int NWORDS = HPIX * VPIX / 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       vga_vs = 1'b1;
    logic       blank_n = 1'b0;
    logic       pix_en = 1'b0;
    logic       pix = 1'b0;
    logic       busy, done, err_short;
    logic [1:0] dbg_state;

    vga_capture_if fb ();

    vga_capture #(.HPIX(HPIX), .VPIX(VPIX), .NWORDS(NWORDS)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .VGA_VS      (vga_vs),
        .VGA_BLANK_n (blank_n),
        .pix_en      (pix_en),
        .pix         (pix),
        .fb          (fb),
        .busy        (busy),
        .done        (done),
        .err_short   (err_short),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [46:0] exp_q[$];
    logic [46:0] got_q[$];
    int          got_cyc[$];
    logic        samp_q[$];
    int          samp_cyc[$];
    logic        model_on = 1'b0;
    int          hold_bad = 0;
    logic [14:0] last_addr = '0;
    logic [31:0] last_data = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor; also tracks that address/data hold between strobes.
    always @(negedge clk) begin
        if (reset) begin
            last_addr = '0;
            last_data = '0;
        end else if (fb.fb_write) begin
            got_q.push_back({fb.fb_address, fb.fb_writedata});
            got_cyc.push_back(cyc);
            last_addr = fb.fb_address;
            last_data = fb.fb_writedata;
        end else if (fb.fb_address !== last_addr || fb.fb_writedata !== last_data) begin
            hold_bad++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic b, input logic e, input logic p);
        vga_vs  = v;
        blank_n = b;
        pix_en  = e;
        pix     = p;
        if (model_on && b && e) begin
            samp_q.push_back(p);
            samp_cyc.push_back(cyc);
            if (samp_q.size() == NWORDS * 32) model_on = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic arm(input string tag);
        start = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        check({tag, "_busy_armed"}, busy, 1);
        check({tag, "_done_cleared"}, done, 0);
        check({tag, "_err_cleared"}, err_short, 0);
    endtask

    // pat: 0 random, 1 all ones, 2 first word 1,0..0,1 then random
    task automatic send_frame(input int pat, input bit armed, input bit dense,
                              input int cut_at, input bit cut_sample,
                              input int reset_at, input int start_at);
        int   n = 0;
        logic p;
        repeat (4) drive(1'b1, 1'b0, rbit(), rbit());
        repeat (3) drive(1'b0, 1'b0, rbit(), rbit());
        repeat (4) drive(1'b1, 1'b0, rbit(), rbit());
        model_on = armed;
        for (int line = 0; line < VPIX; line++) begin
            int s = 0;
            while (s < HPIX) begin
                if (!dense && $urandom_range(0, 3) == 0) begin
                    drive(1'b1, 1'b1, 1'b0, rbit());
                    continue;
                end
                if (pat == 1)                p = 1'b1;
                else if (pat == 2 && n < 32) p = (n == 0 || n == 31);
                else                         p = rbit();
                if (n == cut_at) begin
                    if (cut_sample) drive(1'b0, 1'b1, 1'b1, p);
                    model_on = 1'b0;
                    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
                    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
                    return;
                end
                if (n == reset_at) begin
                    model_on = 1'b0;
                    reset = 1'b1;
                    drive(1'b1, 1'b1, 1'b1, p);
                    reset = 1'b0;
                    check("busy_after_reset", busy, 0);
                end else begin
                    if (n == start_at) start = 1'b1;
                    drive(1'b1, 1'b1, 1'b1, p);
                    start = 1'b0;
                end
                n++;
                s++;
            end
            repeat (6) drive(1'b1, 1'b0, rbit(), rbit());
        end
        repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- reference model / compare ----------------
    task automatic compare_frame(input string tag, input logic exp_done, input logic exp_err);
        int nw = samp_q.size() / 32;
        if (nw > NWORDS) nw = NWORDS;
        exp_q.delete();
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            for (int k = 0; k < 32; k++) d[k] = samp_q[32 * w + k];
            exp_q.push_back({15'(w), d});
        end
        check({tag, "_nwrites"}, got_q.size(), nw);
        for (int i = 0; i < got_q.size() && i < nw; i++) begin
            check($sformatf("%s_addr%0d", tag, i), got_q[i][46:32], exp_q[i][46:32]);
            check($sformatf("%s_data%0d", tag, i), got_q[i][31:0], exp_q[i][31:0]);
        end
        check({tag, "_done"}, done, exp_done);
        check({tag, "_err_short"}, err_short, exp_err);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_state_idle"}, dbg_state, 0);
        check({tag, "_hold"}, hold_bad, 0);
    endtask

    task automatic clear_sb();
        got_q.delete();
        got_cyc.delete();
        samp_q.delete();
        samp_cyc.delete();
        exp_q.delete();
        hold_bad = 0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_fb_write", fb.fb_write, 0);
        check("rst_fb_address", fb.fb_address, 0);
        check("rst_fb_writedata", fb.fb_writedata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err_short", err_short, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b0;
        hold_bad = 0;

        // frame with no start request must be ignored
        send_frame(0, 1'b0, 1'b0, -1, 1'b0, -1, -1);
        compare_frame("idle", 1'b0, 1'b0);
        clear_sb();

        arm("ones");
        send_frame(1, 1'b1, 1'b0, -1, 1'b0, -1, -1);
        compare_frame("ones", 1'b1, 1'b0);
        check("ones_last_data", got_q.size() > 0 ? got_q[got_q.size() - 1][31:0] : 32'h0, 32'hFFFF_FFFF);
        clear_sb();

        arm("order");
        send_frame(2, 1'b1, 1'b0, -1, 1'b0, -1, -1);
        compare_frame("order", 1'b1, 1'b0);
        check("order_word0", got_q.size() > 0 ? got_q[0][31:0] : 32'h0, 32'h8000_0001);
        check("order_latency", got_cyc.size() > 0 ? got_cyc[0] : -1,
              samp_cyc.size() >= 32 ? samp_cyc[31] + 1 : -2);
        clear_sb();

        arm("dense");
        send_frame(0, 1'b1, 1'b1, -1, 1'b0, -1, 100);
        compare_frame("dense", 1'b1, 1'b0);
        check("dense_spacing", got_cyc.size() >= 2 ? got_cyc[1] - got_cyc[0] : -1, 32);
        clear_sb();

        arm("short");
        send_frame(0, 1'b1, 1'b0, 40 * 32 + 5, 1'b0, -1, -1);
        compare_frame("short", 1'b1, 1'b1);
        clear_sb();

        arm("vs_write");
        send_frame(0, 1'b1, 1'b0, 30 * 32 - 1, 1'b1, -1, -1);
        compare_frame("vs_write", 1'b1, 1'b1);
        clear_sb();

        arm("midrst");
        send_frame(0, 1'b1, 1'b0, -1, 1'b0, 50 * 32 + 7, -1);
        compare_frame("midrst", 1'b0, 1'b0);
        clear_sb();

        arm("after_rst");
        send_frame(0, 1'b1, 1'b0, -1, 1'b0, -1, -1);
        compare_frame("after_rst", 1'b1, 1'b0);
        check("after_rst_addr0", got_q.size() > 0 ? got_q[0][46:32] : 15'h7fff, 0);
        clear_sb();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
